// File: rtl/alarm_service_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alarm_service_if                                              |
// | Purpose  : Bus between the alarm sequencer and the alarm-set service.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface alarm_service_if;
  logic        set_en;
  logic        set_push_u;
  logic        set_push_d;
  logic        set_push_l;
  logic        set_push_r;
  logic [15:0] set_num;
  logic [3:0]  set_an;
  logic [15:0] set_alarm;
  logic        set_finish;

  modport master (
    output set_en, set_push_u, set_push_d, set_push_l, set_push_r,
    input  set_num, set_an, set_alarm, set_finish
  );

  modport slave (
    input  set_en, set_push_u, set_push_d, set_push_l, set_push_r,
    output set_num, set_an, set_alarm, set_finish
  );
endinterface
`default_nettype wire

// File: rtl/alarm_service_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alarm_service_ctrl                                            |
// | Purpose  : mm:ss timekeeping, display/button arbitration and alarm       |
// |            ring/snooze/dismiss sequencing. Macro ALARM_SNOOZE_EN adds    |
// |            the SNOOZE state.                                             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alarm_service_ctrl #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 60
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        spdt_set,
  input  wire logic        push_u,
  input  wire logic        push_d,
  input  wire logic        push_l,
  input  wire logic        push_r,
  alarm_service_if.master  svc,
  output logic [15:0]      cur_time,
  output logic [15:0]      disp_num,
  output logic [3:0]       disp_an,
  output logic             ring,
  output logic [1:0]       state
);

  localparam int c_pw       = $clog2(TICK_DIV);
  localparam int c_max_secs = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int c_sw       = $clog2(c_max_secs + 1);

  localparam logic [c_pw-1:0] c_div_last  = c_pw'(TICK_DIV - 1);
  localparam logic [c_sw-1:0] c_ring_last = c_sw'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [c_sw-1:0] c_snooze_last = c_sw'(SNOOZE_SECS - 1);
  localparam logic [1:0]      c_st_snooze   = 2'd3;
`endif

  localparam logic [1:0] c_st_clock = 2'd0;
  localparam logic [1:0] c_st_set   = 2'd1;
  localparam logic [1:0] c_st_ring  = 2'd2;

  logic [c_pw-1:0] presc_q, presc_d;
  logic [15:0]     time_q, time_d;
  logic            upd_q, upd_d;
  logic [15:0]     alarm_q, alarm_d;
  logic            alarm_valid_q, alarm_valid_d;
  logic            fin_prev_q, fin_prev_d;
  logic [1:0]      state_q, state_d;
  logic [c_sw-1:0] sec_q, sec_d;
  logic            blink_q, blink_d;

  logic tick, fin_rise, match, any_ulr;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      time_q        <= '0;
      upd_q         <= 1'b0;
      alarm_q       <= '0;
      alarm_valid_q <= 1'b0;
      fin_prev_q    <= 1'b0;
      state_q       <= c_st_clock;
      sec_q         <= '0;
      blink_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      time_q        <= time_d;
      upd_q         <= upd_d;
      alarm_q       <= alarm_d;
      alarm_valid_q <= alarm_valid_d;
      fin_prev_q    <= fin_prev_d;
      state_q       <= state_d;
      sec_q         <= sec_d;
      blink_q       <= blink_d;
    end
  end

  // Prescaler, BCD time and alarm latch
  always_comb begin
    tick    = (presc_q == c_div_last);
    presc_d = tick ? '0 : presc_q + 1'b1;
    upd_d   = tick;
    time_d  = time_q;
    if (tick) begin
      if (time_q[3:0] != 4'd9) begin
        time_d[3:0] = time_q[3:0] + 4'd1;
      end else begin
        time_d[3:0] = 4'd0;
        if (time_q[7:4] != 4'd5) begin
          time_d[7:4] = time_q[7:4] + 4'd1;
        end else begin
          time_d[7:4] = 4'd0;
          if (time_q[11:8] != 4'd9) begin
            time_d[11:8] = time_q[11:8] + 4'd1;
          end else begin
            time_d[11:8]  = 4'd0;
            time_d[15:12] = (time_q[15:12] == 4'd5) ? 4'd0 : time_q[15:12] + 4'd1;
          end
        end
      end
    end
    fin_rise      = svc.set_finish & ~fin_prev_q;
    fin_prev_d    = svc.set_finish;
    alarm_d       = fin_rise ? svc.set_alarm : alarm_q;
    alarm_valid_d = alarm_valid_q | fin_rise;
    match         = upd_q & alarm_valid_q & (time_q == alarm_q);
  end

  // Next-state logic
  always_comb begin
    any_ulr = push_u | push_l | push_r;
    state_d = state_q;
    case (state_q)
      c_st_clock: begin
        if (spdt_set)   state_d = c_st_set;
        else if (match) state_d = c_st_ring;
      end
      c_st_set: begin
        if (!spdt_set) state_d = c_st_clock;
      end
      c_st_ring: begin
`ifdef ALARM_SNOOZE_EN
        if (push_d)       state_d = c_st_snooze;
        else if (any_ulr) state_d = c_st_clock;
`else
        if (any_ulr | push_d) state_d = c_st_clock;
`endif
        else if (tick && sec_q == c_ring_last) state_d = c_st_clock;
      end
`ifdef ALARM_SNOOZE_EN
      c_st_snooze: begin
        if (any_ulr)                                state_d = c_st_clock;
        else if (tick && sec_q == c_snooze_last)    state_d = c_st_ring;
      end
`endif
      default: state_d = c_st_clock;
    endcase
  end

  // Seconds counter and blink phase restart on every state change
  always_comb begin
    sec_d   = sec_q;
    blink_d = blink_q;
    if (state_d != state_q) begin
      sec_d   = '0;
      blink_d = 1'b0;
    end else if (tick && state_q[1]) begin
      sec_d   = sec_q + 1'b1;
      blink_d = (state_q == c_st_ring) ? ~blink_q : blink_q;
    end
  end

  // Outputs
  always_comb begin
    cur_time       = time_q;
    state          = state_q;
    ring           = (state_q == c_st_ring);
    svc.set_en     = (state_q == c_st_set);
    svc.set_push_u = push_u & (state_q == c_st_set);
    svc.set_push_d = push_d & (state_q == c_st_set);
    svc.set_push_l = push_l & (state_q == c_st_set);
    svc.set_push_r = push_r & (state_q == c_st_set);
    disp_num       = time_q;
    disp_an        = 4'b0000;
    case (state_q)
      c_st_set: begin
        disp_num = svc.set_num;
        disp_an  = svc.set_an;
      end
      c_st_ring: disp_an = blink_q ? 4'b1111 : 4'b0000;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_service_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alarm_service_ctrl                                         |
// | Purpose  : Directed self-checking bench for alarm_service_ctrl.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_alarm_service_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        spdt_set, push_u, push_d, push_l, push_r;
  logic [15:0] cur_time, disp_num;
  logic [3:0]  disp_an;
  logic        ring;
  logic [1:0]  state;
  int          errors = 0;
  int          checks = 0;

  alarm_service_if svc_if ();

  alarm_service_ctrl #(.TICK_DIV(4), .RING_SECS(3), .SNOOZE_SECS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .spdt_set (spdt_set),
    .push_u   (push_u),
    .push_d   (push_d),
    .push_l   (push_l),
    .push_r   (push_r),
    .svc      (svc_if.master),
    .cur_time (cur_time),
    .disp_num (disp_num),
    .disp_an  (disp_an),
    .ring     (ring),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_time(input logic [15:0] t, input string tag);
    int n;
    n = 0;
    while (cur_time !== t && n < 400) begin
      run(1);
      n++;
    end
    chk(tag, cur_time, t);
  endtask

  // Re-arm the finish edge from inside SET, then latch a new alarm on the way out
  task automatic program_alarm(input logic [15:0] a);
    spdt_set = 1'b1;
    svc_if.set_finish = 1'b0;
    run(1);
    svc_if.set_alarm  = a;
    svc_if.set_finish = 1'b1;
    spdt_set = 1'b0;
    run(1);
  endtask

  initial begin
    reset = 1'b1;
    spdt_set = 1'b0;
    push_u = 1'b0; push_d = 1'b0; push_l = 1'b0; push_r = 1'b0;
    svc_if.set_num    = 16'h0000;
    svc_if.set_an     = 4'b1111;
    svc_if.set_alarm  = 16'h0000;
    svc_if.set_finish = 1'b0;
    run(2);
    chk("rst_state", state, 2'd0);
    chk("rst_time", cur_time, 16'h0000);
    chk("rst_ring", ring, 1'b0);
    chk("rst_an", disp_an, 4'b0000);
    chk("rst_num", disp_num, 16'h0000);
    chk("rst_set_en", svc_if.set_en, 1'b0);
    reset = 1'b0;

    run(240);
    chk("time_0100", cur_time, 16'h0100);
    run(14152);
    chk("time_5958", cur_time, 16'h5958);
    run(4);
    chk("time_5959", cur_time, 16'h5959);
    run(4);
    chk("time_wrap", cur_time, 16'h0000);
    run(24);
    chk("time_0006", cur_time, 16'h0006);

    spdt_set = 1'b1;
    run(1);
    chk("set_state", state, 2'd1);
    chk("set_en", svc_if.set_en, 1'b1);
    svc_if.set_num = 16'h1234;
    svc_if.set_an  = 4'b1010;
    push_u = 1'b1;
    #1;
    chk("set_push_u", svc_if.set_push_u, 1'b1);
    chk("set_push_d_idle", svc_if.set_push_d, 1'b0);
    chk("set_disp_num", disp_num, 16'h1234);
    chk("set_disp_an", disp_an, 4'b1010);
    run(1);
    push_u = 1'b0;

    svc_if.set_alarm  = 16'h0010;
    svc_if.set_finish = 1'b1;
    spdt_set = 1'b0;
    run(1);
    chk("latch_state", state, 2'd0);
    chk("latch_alarm", dut.alarm_q, 16'h0010);
    chk("latch_valid", dut.alarm_valid_q, 1'b1);
    svc_if.set_alarm = 16'h0099;
    run(2);
    chk("finish_level_no_relatch", dut.alarm_q, 16'h0010);

    wait_time(16'h0010, "reach_0010");
    chk("match_latency", state, 2'd0);
    run(1);
    chk("ring_state", state, 2'd2);
    chk("ring_on", ring, 1'b1);
    chk("ring_an_entry", disp_an, 4'b0000);
    chk("ring_num", disp_num, 16'h0010);
    run(3);
    chk("ring_an_tick1", disp_an, 4'b1111);
    run(3);
    chk("ring_an_hold", disp_an, 4'b1111);
    run(1);
    chk("ring_an_tick2", disp_an, 4'b0000);
    run(3);
    chk("ring_before_timeout", state, 2'd2);
    run(1);
    chk("ring_timeout_state", state, 2'd0);
    chk("ring_timeout_ring", ring, 1'b0);

    program_alarm(16'h0020);
    chk("alarm2", dut.alarm_q, 16'h0020);
    wait_time(16'h0020, "reach_0020");
    run(1);
    chk("ring2_state", state, 2'd2);
    push_d = 1'b1;
    run(1);
    push_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
    chk("snooze_state", state, 2'd3);
    chk("snooze_ring", ring, 1'b0);
    chk("snooze_an", disp_an, 4'b0000);
    run(5);
    chk("snooze_hold", state, 2'd3);
    run(1);
    chk("resnooze_ring_state", state, 2'd2);
    chk("resnooze_ring", ring, 1'b1);
    chk("resnooze_an", disp_an, 4'b0000);
    push_l = 1'b1;
    #1;
    chk("ring_no_fwd_l", svc_if.set_push_l, 1'b0);
    run(1);
    push_l = 1'b0;
    chk("dismiss_l_state", state, 2'd0);
    chk("dismiss_l_ring", ring, 1'b0);
`else
    chk("dismiss_d_state", state, 2'd0);
    chk("dismiss_d_ring", ring, 1'b0);
`endif

    program_alarm(16'h0030);
    chk("alarm3", dut.alarm_q, 16'h0030);
    spdt_set = 1'b1;
    run(1);
    chk("tie_set_state", state, 2'd1);
    wait_time(16'h0030, "reach_0030");
    run(2);
    chk("tie_stays_set", state, 2'd1);
    chk("tie_no_ring", ring, 1'b0);

    svc_if.set_finish = 1'b0;
    run(1);
    svc_if.set_alarm  = 16'h0040;
    svc_if.set_finish = 1'b1;
    spdt_set = 1'b0;
    run(1);
    chk("alarm4_state", state, 2'd0);
    chk("alarm4", dut.alarm_q, 16'h0040);
    push_r = 1'b1;
    #1;
    chk("clock_no_fwd_r", svc_if.set_push_r, 1'b0);
    chk("clock_set_en", svc_if.set_en, 1'b0);
    run(1);
    push_r = 1'b0;
    chk("clock_push_r_state", state, 2'd0);

    wait_time(16'h0040, "reach_0040");
    run(1);
    chk("ring4_state", state, 2'd2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_ring", ring, 1'b0);
    chk("mid_rst_valid", dut.alarm_valid_q, 1'b0);
    chk("mid_rst_time", cur_time, 16'h0000);
    chk("mid_rst_an", disp_an, 4'b0000);
    run(8);
    chk("post_rst_time", cur_time, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
